writeback_regfile: RTL and testbench

Writeback stage and integer register file for the 5-stage RV32I pipeline. It consumes the MEM/WB pipeline register outputs and selects the writeback result. It commits that result into a 32×32 register file and serves the two combinational read ports used by Decode. It also drives ResultW to the hazard/forwarding unit and keeps a 64-bit retired-instruction counter.

---
 rtl/writeback_regfile.sv | 81 ++++++++
 tb/tb_writeback_regfile.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback result select, 32x32 integer register file with two combinational
// read ports, and a 64-bit retired-instruction counter. Optional macro:
// WRITEBACK_REGFILE_BYPASS_EN (same-cycle write-through to the read ports).
module writeback_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic            ValidW,
    input  logic [4:0]      A1D,
    input  logic [4:0]      A2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [63:0]     InstRetW
);

    // No handshake: W inputs are sampled on every edge; a stalled or flushed
    // W slot simply arrives with ValidW=0 and neither writes nor retires.
    logic [XLEN-1:0] regs [0:NREG-1];
    logic            we;

    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    assign we = ValidW && RegWriteW && (RdW != 5'd0) && (ResultSrcW != 2'b11);

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[RdW] <= ResultW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            InstRetW <= '0;
        end else if (ValidW) begin
            InstRetW <= InstRetW + 64'd1;
        end
    end

    always_comb begin
        RD1D = '0;
        RD2D = '0;
        if (A1D != 5'd0) begin
            RD1D = regs[A1D];
        end
        if (A2D != 5'd0) begin
            RD2D = regs[A2D];
        end
`ifdef WRITEBACK_REGFILE_BYPASS_EN
        // we already excludes x0, so the zero-register rule survives the bypass.
        if (we && (A1D == RdW)) begin
            RD1D = ResultW;
        end
        if (we && (A2D == RdW)) begin
            RD2D = ResultW;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed sequences, a vector table,
// and randomized traffic against an array-based reference model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [1:0]  ResultSrcW = '0;
    logic [31:0] ALUResultW = '0;
    logic [31:0] ReadDataW = '0;
    logic [31:0] PCPlus4W = '0;
    logic        ValidW = 1'b0;
    logic [4:0]  A1D = '0;
    logic [4:0]  A2D = '0;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [63:0] InstRetW;

    writeback_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .ValidW(ValidW), .A1D(A1D), .A2D(A2D),
        .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .InstRetW(InstRetW)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0]     modelRegs [32];
    longint unsigned modelCnt = 0;
    logic [63:0]     expQ[$];
    int              passCnt = 0;
    int              totalCnt = 0;

`ifdef WRITEBACK_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] refResult(input logic [1:0] src, input logic [31:0] alu,
                                              input logic [31:0] rdat, input logic [31:0] pc);
        if (src == 2'd0) return alu;
        if (src == 2'd1) return rdat;
        if (src == 2'd2) return pc;
        return 32'd0;
    endfunction

    function automatic logic [31:0] refRead(input logic [4:0] a, input logic wr,
                                            input logic [4:0] rd, input logic [31:0] res);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && wr && a == rd) return res;
        return modelRegs[a];
    endfunction

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc,
                         input logic [4:0] a1, input logic [4:0] a2);
        ValidW = v; RegWriteW = rw; RdW = rd; ResultSrcW = src;
        ALUResultW = alu; ReadDataW = rdat; PCPlus4W = pc; A1D = a1; A2D = a2;
    endtask

    // Check combinational outputs, advance the model, clock once, check the counter.
    task automatic step();
        logic [31:0] res;
        logic        wr;
        #1;
        res = refResult(ResultSrcW, ALUResultW, ReadDataW, PCPlus4W);
        wr  = ValidW && RegWriteW && (RdW != 0) && (ResultSrcW != 2'd3);
        check("resultW", {32'd0, ResultW}, {32'd0, res});
        check("rd1", {32'd0, RD1D}, {32'd0, refRead(A1D, wr, RdW, res)});
        check("rd2", {32'd0, RD2D}, {32'd0, refRead(A2D, wr, RdW, res)});
        if (reset) begin
            for (int i = 0; i < 32; i++) modelRegs[i] = '0;
            modelCnt = 0;
        end else begin
            if (ValidW) modelCnt++;
            if (wr) modelRegs[RdW] = res;
        end
        expQ.push_back(modelCnt);
        @(posedge clk);
        #1;
        check("instRet", InstRetW, expQ.pop_front());
    endtask

    typedef struct {
        logic        v, rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu, rdat, pc;
        logic [4:0]  a1, a2;
        logic [31:0] expRes;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] expAfter[6];

    initial begin
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;

        // Clock/reset
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: every index reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            #1;
            check("reset_rd1", {32'd0, RD1D}, 64'd0);
            check("reset_rd2", {32'd0, RD2D}, 64'd0);
        end
        check("reset_instret", InstRetW, 64'd0);

        // Load into x5 with a same-cycle read.
        drive(1, 1, 5, 2'b01, 32'h0, 32'hDEADBEEF, 32'h0, 5, 0);
        #1;
        check("same_cycle_rd1", {32'd0, RD1D}, BYPASS ? 64'hDEADBEEF : 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 5);
        #1;
        check("x5_after", {32'd0, RD1D}, 64'hDEADBEEF);
        check("x5_after_p2", {32'd0, RD2D}, 64'hDEADBEEF);
        step();

        // Write to x0 is dropped but still retires.
        drive(1, 1, 0, 2'b00, 32'h1234, 0, 0, 0, 0);
        step();
        check("x0_instret", InstRetW, 64'd2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("x0_rd1", {32'd0, RD1D}, 64'd0);
        check("x0_rd2", {32'd0, RD2D}, 64'd0);

        // Link address into x1, then a bubble aimed at x1.
        drive(1, 1, 1, 2'b10, 0, 0, 32'h104, 1, 0);
        step();
        drive(0, 1, 1, 2'b00, 32'h55, 0, 0, 1, 1);
        step();
        check("x1_bubble", {32'd0, RD1D}, 64'h104);
        check("bubble_instret", InstRetW, 64'd3);

        // Reserved select: ResultW=0 and no write.
        drive(1, 1, 7, 2'b00, 32'h77, 0, 0, 7, 0);
        step();
        drive(1, 1, 7, 2'b11, 32'hAAAA, 32'hBBBB, 32'hCCCC, 7, 7);
        #1;
        check("reserved_result", {32'd0, ResultW}, 64'd0);
        step();
        check("x7_kept", {32'd0, RD1D}, 64'h77);

        // Reset wins over a same-edge write and retirement.
        reset = 1'b1;
        drive(1, 1, 3, 2'b00, 32'h333, 0, 0, 3, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 3, 7);
        #1;
        check("reset_x3", {32'd0, RD1D}, 64'd0);
        check("reset_x7", {32'd0, RD2D}, 64'd0);
        check("reset_cnt", InstRetW, 64'd0);

        // Ten retirements with mixed RegWriteW, reset, then resume.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1'(i % 2), 5'($urandom_range(1, 31)), 2'b00, $urandom, 0, 0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            step();
        end
        check("ten_retired", InstRetW, 64'd10);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        check("mid_reset_cnt", InstRetW, 64'd0);
        step();
        check("resume_cnt", InstRetW, 64'd1);

        // Vector table.
        vecs[0] = '{1, 1, 10, 2'b00, 32'h000000AA, 32'h1, 32'h2, 10, 0, 32'h000000AA};
        vecs[1] = '{1, 1, 11, 2'b01, 32'h3, 32'hCAFEF00D, 32'h4, 10, 11, 32'hCAFEF00D};
        vecs[2] = '{1, 1, 12, 2'b10, 32'h5, 32'h6, 32'h00000208, 11, 12, 32'h00000208};
        vecs[3] = '{1, 1, 13, 2'b11, 32'h7, 32'h8, 32'h9, 12, 13, 32'h0};
        vecs[4] = '{0, 1, 14, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 14, 10, 32'hFFFFFFFF};
        vecs[5] = '{1, 0, 15, 2'b01, 32'h0, 32'h1357, 32'h0, 15, 14, 32'h00001357};
        vecs[6] = '{1, 1, 10, 2'b00, 32'h80000000, 32'h0, 32'h0, 10, 10, 32'h80000000};
        vecs[7] = '{1, 1, 0, 2'b10, 32'h0, 32'h0, 32'h44, 0, 10, 32'h00000044};
        expAfter = '{32'h80000000, 32'hCAFEF00D, 32'h00000208, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].rd, vecs[i].src, vecs[i].alu,
                  vecs[i].rdat, vecs[i].pc, vecs[i].a1, vecs[i].a2);
            #1;
            check("vec_result", {32'd0, ResultW}, {32'd0, vecs[i].expRes});
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 5'(10 + i), 5'(10 + i));
            #1;
            check("vec_regs", {32'd0, RD1D}, {32'd0, expAfter[i]});
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) A1D = RdW;
            if ($urandom_range(0, 3) == 0) A2D = RdW;
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
